// File: rtl/pipelined_instruction_memory.sv
// -----------------------------------------------------------------------------
// pipelined_instruction_memory
//
// Byte-addressed instruction memory for the fetch stage. Fetches use a
// valid/ready handshake and come back READ_LATENCY cycles later through a
// shift pipeline that stalls as a whole under backpressure. A write-only load
// port fills the array at runtime. Misaligned or out-of-range fetches return
// NOP_WORD with rsp_err set.
//
// Ports
//    clk        : rising-edge clock
//    rst_n      : asynchronous active-low reset (array contents survive it)
//    req_valid  : fetch request present
//    req_ready  : request is taken on this edge when high with req_valid
//    req_addr   : byte address of the instruction
//    rsp_valid  : response present on rsp_instr/rsp_err
//    rsp_ready  : consumer takes the response on this edge
//    rsp_instr  : fetched word, or NOP_WORD for an error response
//    rsp_err    : response came from a misaligned or out-of-range address
//    flush      : drop every in-flight request, including the one on rsp_*
//    load_en    : write load_data into word load_idx on this edge
//    load_idx   : word index for the load port
//    load_data  : word to write
// -----------------------------------------------------------------------------
module pipelined_instruction_memory #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    DEPTH        = 512,
   parameter int                    READ_LATENCY = 2,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD     = DATA_WIDTH'(32'h00000013)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_WIDTH-1:0]    req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_instr,
   output logic                     rsp_err,
   input  logic                     flush,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_idx,
   input  logic [DATA_WIDTH-1:0]    load_data
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int LAST  = READ_LATENCY - 1;

   // Instruction storage. Deliberately not reset so that a program loaded
   // before a reset is still there afterwards.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Pipeline stages: stage 0 is filled at the accepting edge, stage LAST
   // drives the response outputs.
   logic [READ_LATENCY-1:0]                 vld_q, vld_d;
   logic [READ_LATENCY-1:0]                 err_q, err_d;
   logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_q, dat_d;

   logic                  stall;
   logic                  accept;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  req_err;
   logic [IDX_W-1:0]      word_idx;
   logic [DATA_WIDTH-1:0] req_word;

   assign word_idx   = req_addr[IDX_W+1:2];
   assign misaligned = |req_addr[1:0];

   // DEPTH is a power of two, so "addr >= 4*DEPTH" is the same as any address
   // bit above the word index being set. When the address is exactly as wide
   // as the array, nothing can be out of range.
   generate
      if (ADDR_WIDTH > IDX_W + 2) begin : g_range
         assign out_of_range = |req_addr[ADDR_WIDTH-1:IDX_W+2];
      end else begin : g_no_range
         assign out_of_range = 1'b0;
      end
   endgenerate

   assign req_err = misaligned | out_of_range;

   // The array is read at the acceptance edge; error responses substitute
   // the NOP instead of using the array word.
   assign req_word = req_err ? NOP_WORD : mem_q[word_idx];

   // Handshake. rst_n is folded in so nothing is accepted while the block is
   // held in reset.
   assign stall     = vld_q[LAST] & ~rsp_ready;
   assign req_ready = rst_n & ~stall & ~flush & ~load_en;
   assign accept    = req_valid & req_ready;

   // Response outputs come straight from the last stage. rsp_err is qualified
   // by valid so a stale error bit in a bubble is never visible.
   assign rsp_valid = vld_q[LAST];
   assign rsp_err   = vld_q[LAST] & err_q[LAST];
   assign rsp_instr = dat_q[LAST];

   // Load port write. A fetch already accepted has its word captured in
   // stage 0, so a load to the same word never alters that response.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem_q[load_idx] <= load_data;
      end
   end

   // Next-state for the stage pipeline. Flush wins over everything and empties
   // every stage; a stall freezes all stages; otherwise everything, bubbles
   // included, moves one stage forward and stage 0 takes the new request (or a
   // bubble). Payload is only captured on acceptance so bubbles do not toggle
   // the data path.
   always_comb begin
      vld_d = vld_q;
      err_d = err_q;
      dat_d = dat_q;
      if (flush) begin
         vld_d = '0;
      end else if (!stall) begin
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
         end
         vld_d[0] = accept;
         if (accept) begin
            err_d[0] = req_err;
            dat_d[0] = req_word;
         end
      end
   end

   // Stage registers. Reset clears the payload too so rsp_instr reads zero
   // while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         err_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         err_q <= err_d;
         dat_q <= dat_d;
      end
   end

endmodule
